data_sram_responder: RTL

Responder end of the data SRAM interface: accepts the CPU core's `data_sram_*` requests and serves them from an on-chip word RAM or a small confreg MMIO window (LED, number display, free-running timer, simulation flag). It sits in the SoC top between the core's data port and the board outputs. It replaces the ideal zero-latency data memory with a registered-read responder for the pipelined core.

---
 rtl/data_sram_responder.sv | 112 +++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: serves core load/store requests from an on-chip
// word RAM or the confreg MMIO window (timer, LED, number display, sim flag).
module data_sram_responder #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] CONF_BASE  = 32'hbfaf_0000,
  parameter logic        SIMU_FLAG  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num
);

  localparam logic [15:0] OFF_TIMER = 16'he000;
  localparam logic [15:0] OFF_LED   = 16'hf000;
  localparam logic [15:0] OFF_NUM   = 16'hf010;
  localparam logic [15:0] OFF_SIMU  = 16'hf020;

  logic [31:0] mem [0:(2**ADDR_WIDTH)-1];
  logic [31:0] timer;

  logic                  is_mmio;
  logic                  is_write;
  logic                  is_read;
  logic [15:0]           offset;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  ram_wr;
  logic                  timer_wr;
  logic                  led_wr;
  logic                  num_wr;
  logic [31:0]           led_merged;
  logic [31:0]           read_word;
  logic                  unused_bits;

  // Replace only the byte lanes whose write enable is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return r;
  endfunction

  assign is_mmio  = (data_sram_addr[31:16] == CONF_BASE[31:16]);
  assign offset   = data_sram_addr[15:0];
  assign ram_idx  = data_sram_addr[ADDR_WIDTH+1:2];
  assign is_write = data_sram_en && (data_sram_we != 4'h0);
  assign is_read  = data_sram_en && (data_sram_we == 4'h0);

  assign ram_wr   = is_write && !is_mmio;
  assign timer_wr = is_write && is_mmio && (offset == OFF_TIMER);
  assign led_wr   = is_write && is_mmio && (offset == OFF_LED);
  assign num_wr   = is_write && is_mmio && (offset == OFF_NUM);

  assign led_merged  = byte_merge({16'h0, led}, data_sram_wdata, data_sram_we);
  assign unused_bits = ^{data_sram_addr[1:0], led_merged[31:16]};

  always_comb begin
    read_word = 32'h0;
    if (is_mmio) begin
      case (offset)
        OFF_TIMER: read_word = timer;
        OFF_LED:   read_word = {16'h0, led};
        OFF_NUM:   read_word = num;
        OFF_SIMU:  read_word = {31'h0, SIMU_FLAG};
        default:   read_word = 32'h0;
      endcase
    end else begin
      read_word = mem[ram_idx];
    end
  end

  // Registered read port and confreg state; a timer write replaces that edge's increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_sram_rdata <= 32'h0;
      led             <= 16'hffff;
      num             <= 32'h0;
      timer           <= 32'h0;
    end else begin
      if (timer_wr) begin
        timer <= byte_merge(timer, data_sram_wdata, data_sram_we);
      end else begin
        timer <= timer + 32'd1;
      end
      if (led_wr) begin
        led <= led_merged[15:0];
      end
      if (num_wr) begin
        num <= byte_merge(num, data_sram_wdata, data_sram_we);
      end
      if (is_read) begin
        data_sram_rdata <= read_word;
      end
    end
  end

  // RAM contents are never reset; a request coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && ram_wr) begin
      mem[ram_idx] <= byte_merge(mem[ram_idx], data_sram_wdata, data_sram_we);
    end
  end

endmodule
